// File: rtl/memx_row_packer.sv
// Row packer for the X vector memory: gathers no_of_units elements per row and
// issues one single-cycle row write per row. Define MEMX_PACK_FLUSH_EN to add a partial-row flush input.
module memx_row_packer #(
  parameter int no_of_units   = 8,
  parameter int element_width = 32,
  parameter int memory_height = 1000,
  parameter int address_width = $clog2(memory_height) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic [address_width-1:0]             row_count,
  input  logic [element_width-1:0]             in_data,
  input  logic                                 in_valid,
`ifdef MEMX_PACK_FLUSH_EN
  input  logic                                 flush,
`endif
  output logic                                 in_ready,
  output logic                                 write_enable,
  output logic [address_width-1:0]             input_write_address,
  output logic [no_of_units*element_width-1:0] input_data,
  output logic                                 busy,
  output logic                                 done
);
  localparam int ROW_W  = no_of_units * element_width;
  localparam int LANE_W = (no_of_units > 1) ? $clog2(no_of_units) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(no_of_units - 1);

  // Handshake: an element transfers on any cycle with in_valid && in_ready;
  // the source holds in_data stable until that cycle.
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;
  state_t state, state_nxt;

  logic [LANE_W-1:0]        lane_cnt;
  logic [address_width-1:0] row_idx, base_q, count_q;
  logic [ROW_W-1:0]         row_buf, row_merged;
  logic                     flush_q;
  logic                     accept, flush_req, row_full, last_row, do_write;
  logic [LANE_W:0]          lanes_after;

  assign accept = (state == S_FILL) && in_valid;
`ifdef MEMX_PACK_FLUSH_EN
  assign flush_req = (state == S_FILL) && flush;
`else
  assign flush_req = 1'b0;
`endif
  assign row_full    = accept && (lane_cnt == LAST_LANE);
  assign last_row    = (row_idx == count_q - address_width'(1));
  assign lanes_after = {1'b0, lane_cnt} + {{LANE_W{1'b0}}, accept};
  // A flush writes only if the row holds at least one element after this cycle's accept.
  assign do_write    = row_full || (flush_req && (lanes_after != '0));

  always_comb begin
    row_merged = row_buf;
    if (accept) row_merged[lane_cnt*element_width +: element_width] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    write_enable = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (row_count == '0) ? S_DONE : S_FILL;
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (do_write)       state_nxt = S_WRITE;
        else if (flush_req) state_nxt = S_DONE;
      end
      S_WRITE: begin
        write_enable = 1'b1;
        state_nxt    = (last_row || flush_q) ? S_DONE : S_FILL;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The write port registers load on entry to WRITE so they hold between writes,
  // letting the pack buffer be cleared for the next row at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt            <= '0;
      row_idx             <= '0;
      base_q              <= '0;
      count_q             <= '0;
      row_buf             <= '0;
      flush_q             <= 1'b0;
      input_write_address <= '0;
      input_data          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_address;
            count_q  <= row_count;
            row_buf  <= '0;
            lane_cnt <= '0;
            row_idx  <= '0;
            flush_q  <= 1'b0;
          end
        end
        S_FILL: begin
          if (do_write) begin
            input_data          <= row_merged;
            input_write_address <= base_q + row_idx;
            row_buf             <= '0;
            lane_cnt            <= '0;
            flush_q             <= flush_req;
          end else if (accept) begin
            row_buf  <= row_merged;
            lane_cnt <= lane_cnt + LANE_W'(1);
          end
        end
        S_WRITE: begin
          if (!last_row && !flush_q) row_idx <= row_idx + address_width'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
